// File: rtl/risc_pkg.sv
// Shared constants and types for the 13-bit RISC core front end.
// HALT_WORD is only meaningful when FETCH_HALT_ON_ZERO_EN is defined.
package risc_pkg;

    localparam int RISC_ADDR_W  = 5;
    localparam int RISC_INSTR_W = 13;
    localparam int RISC_CNT_W   = 8;

    localparam logic [RISC_INSTR_W-1:0] HALT_WORD = '0;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    function automatic logic is_halt_word(input logic [RISC_INSTR_W-1:0] word);
        return word == HALT_WORD;
    endfunction

endpackage

// File: rtl/risc_fetch_unit_if.sv
// Fetch-stage bus: imemory address/data, IR handshake to decode, branch redirect, status.
// master = fetch unit, slave = memory/decode/execute side.
interface risc_fetch_unit_if
    import risc_pkg::*;
#(
    parameter int ADDR_W  = RISC_ADDR_W,
    parameter int INSTR_W = RISC_INSTR_W,
    parameter int CNT_W   = RISC_CNT_W
);
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instruction;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  ir_pc;
    logic               ir_valid;
    logic               ir_ready;
    logic               branch_en;
    logic [ADDR_W-1:0]  branch_target;
    logic               halted;
    logic [CNT_W-1:0]   instr_count;

    modport master (
        output pc, ir, ir_pc, ir_valid, halted, instr_count,
        input  instruction, ir_ready, branch_en, branch_target
    );

    modport slave (
        input  pc, ir, ir_pc, ir_valid, halted, instr_count,
        output instruction, ir_ready, branch_en, branch_target
    );
endinterface

// File: rtl/risc_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Latency: count updates the cycle after en; no backpressure.
module risc_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/risc_fetch_unit.sv
// Instruction fetch: drives pc to imemory, captures word into ir, hands it to decode.
// Latency: word at pc shows on ir one cycle later; ir holds while valid && !ready.
// FETCH_HALT_ON_ZERO_EN: stop fetching on the all-zero halt word until a branch.
module risc_fetch_unit
    import risc_pkg::*;
#(
    parameter int                ADDR_W   = RISC_ADDR_W,
    parameter int                INSTR_W  = RISC_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = RISC_CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    risc_fetch_unit_if.master  bus
);

    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic [ADDR_W-1:0]  ir_pc_q;
    logic               ir_valid_q;
    fetch_state_t       state_q;
    logic               accept;
    logic               advance;

    assign accept  = ir_valid_q && bus.ir_ready;
    assign advance = (state_q == FETCH) && (!ir_valid_q || bus.ir_ready);

`ifdef FETCH_HALT_ON_ZERO_EN
    logic halted_q;
    assign bus.halted = halted_q;
`else
    assign bus.halted = 1'b0;
`endif

    // Branch outranks everything: a pending ir is dropped and fetch restarts at the target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            state_q    <= FETCH;
`ifdef FETCH_HALT_ON_ZERO_EN
            halted_q   <= 1'b0;
`endif
        end else if (bus.branch_en) begin
            pc_q       <= bus.branch_target;
            ir_valid_q <= 1'b0;
            state_q    <= FETCH;
`ifdef FETCH_HALT_ON_ZERO_EN
            halted_q   <= 1'b0;
`endif
        end else if (advance) begin
`ifdef FETCH_HALT_ON_ZERO_EN
            if (is_halt_word(bus.instruction)) begin
                ir_valid_q <= 1'b0;
                state_q    <= HALT;
                halted_q   <= 1'b1;
            end else
`endif
            begin
                ir_q       <= bus.instruction;
                ir_pc_q    <= pc_q;
                ir_valid_q <= 1'b1;
                pc_q       <= pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end else if (accept) begin
            ir_valid_q <= 1'b0;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.ir       = ir_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = ir_valid_q;

    risc_sat_counter #(
        .CNT_W (CNT_W)
    ) u_instr_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (accept),
        .count   (bus.instr_count)
    );

endmodule

// File: tb/tb_risc_fetch_unit.sv
// Directed bench for risc_fetch_unit with a behavioural 32-word instruction memory.
module tb_risc_fetch_unit;
    import risc_pkg::*;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    risc_fetch_unit_if bus ();

    risc_fetch_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Test program: 0..7 = 1c00 + 11*a, fixed words at 9/10/28, halt words at 29..31.
    function automatic logic [12:0] mem_word(input logic [4:0] a);
        logic [12:0] w;
        if (a <= 5'd7)       w = 13'h1c00 + 13'(a) * 13'h011;
        else if (a == 5'd9)  w = 13'h05f1;
        else if (a == 5'd10) w = 13'h06aa;
        else if (a == 5'd28) w = 13'h1e7f;
        else if (a >= 5'd29) w = 13'h0000;
        else                 w = 13'h0800 | 13'(a);
        return w;
    endfunction

    always_comb bus.instruction = mem_word(bus.pc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_ir(input string tag, input logic [12:0] ir, input logic [4:0] ir_pc,
                          input logic vld, input logic [4:0] pc);
        chk({tag, ".ir"}, 32'(bus.ir), 32'(ir));
        chk({tag, ".ir_pc"}, 32'(bus.ir_pc), 32'(ir_pc));
        chk({tag, ".ir_valid"}, 32'(bus.ir_valid), 32'(vld));
        chk({tag, ".pc"}, 32'(bus.pc), 32'(pc));
    endtask

    task automatic chk_zero(input string tag);
        chk_ir(tag, 13'h0, 5'd0, 1'b0, 5'd0);
        chk({tag, ".halted"}, 32'(bus.halted), 32'd0);
        chk({tag, ".count"}, 32'(bus.instr_count), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
    endtask

    initial begin
        total             = 0;
        bad               = 0;
        reset_n           = 1'b0;
        bus.ir_ready      = 1'b1;
        bus.branch_en     = 1'b0;
        bus.branch_target = 5'd0;

        // Reset state, held across a clock edge
        #12;
        chk_zero("reset");
        reset_n = 1'b1;

        // Streaming fetch, one word per cycle
        tick(1);
        chk_ir("first", 13'h1c00, 5'd0, 1'b1, 5'd1);
        chk("first.count", 32'(bus.instr_count), 32'd0);
        tick(7);
        chk_ir("eighth", 13'h1c77, 5'd7, 1'b1, 5'd8);
        tick(2);
        chk_ir("at9", 13'h05f1, 5'd9, 1'b1, 5'd10);
        chk("at9.count", 32'(bus.instr_count), 32'd9);

        // Stall: ir/pc frozen while valid and not accepted
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk_ir("stall", 13'h05f1, 5'd9, 1'b1, 5'd10);
        end
        chk("stall.count", 32'(bus.instr_count), 32'd9);
        bus.ir_ready = 1'b1;
        tick(1);
        chk_ir("release", 13'h06aa, 5'd10, 1'b1, 5'd11);
        chk("release.count", 32'(bus.instr_count), 32'd10);

        // Branch while a stalled ir is pending: ir dropped, not counted
        tick(2);
        chk_ir("pre_br", 13'h0800 | 13'd12, 5'd12, 1'b1, 5'd13);
        bus.ir_ready      = 1'b0;
        bus.branch_en     = 1'b1;
        bus.branch_target = 5'd5;
        tick(1);
        bus.branch_en = 1'b0;
        bus.ir_ready  = 1'b1;
        chk("br.ir_valid", 32'(bus.ir_valid), 32'd0);
        chk("br.pc", 32'(bus.pc), 32'd5);
        chk("br.count", 32'(bus.instr_count), 32'd12);
        tick(1);
        chk_ir("br_tgt", 13'h1c55, 5'd5, 1'b1, 5'd6);

        // Run through the zero words at 29..31
        do_reset();
        tick(29);
        chk_ir("at28", 13'h1e7f, 5'd28, 1'b1, 5'd29);
        tick(1);
`ifdef FETCH_HALT_ON_ZERO_EN
        chk("halt.halted", 32'(bus.halted), 32'd1);
        chk("halt.ir_valid", 32'(bus.ir_valid), 32'd0);
        chk("halt.pc", 32'(bus.pc), 32'd29);
        chk("halt.count", 32'(bus.instr_count), 32'd29);
        tick(3);
        chk("halt_hold.pc", 32'(bus.pc), 32'd29);
        chk("halt_hold.ir_valid", 32'(bus.ir_valid), 32'd0);
        chk("halt_hold.count", 32'(bus.instr_count), 32'd29);
        bus.branch_en     = 1'b1;
        bus.branch_target = 5'd0;
        tick(1);
        bus.branch_en = 1'b0;
        chk("unhalt.halted", 32'(bus.halted), 32'd0);
        chk("unhalt.pc", 32'(bus.pc), 32'd0);
        tick(1);
        chk_ir("unhalt_ld", 13'h1c00, 5'd0, 1'b1, 5'd1);
`else
        chk_ir("zero29", 13'h0000, 5'd29, 1'b1, 5'd30);
        chk("zero29.halted", 32'(bus.halted), 32'd0);
        tick(2);
        chk_ir("zero31", 13'h0000, 5'd31, 1'b1, 5'd0);
        tick(1);
        chk_ir("wrap", 13'h1c00, 5'd0, 1'b1, 5'd1);
        chk("wrap.count", 32'(bus.instr_count), 32'd32);
        chk("wrap.halted", 32'(bus.halted), 32'd0);
`endif

        // Asynchronous reset in the middle of a stall
        tick(3);
        bus.ir_ready = 1'b0;
        tick(2);
        reset_n = 1'b0;
        #1;
        chk_zero("async_rst");
        #2;
        reset_n      = 1'b1;
        bus.ir_ready = 1'b1;

        // Counter saturation: edge k accepts k-1 words
        tick(100);
        chk("cnt99", 32'(bus.instr_count), 32'd99);
        tick(156);
        chk("cnt255", 32'(bus.instr_count), 32'd255);
        tick(45);
        chk("cnt_sat", 32'(bus.instr_count), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
